// File: rtl/fetch_pc_predict.sv
// Fetch-stage PC generator with a direct-mapped BTB and 2-bit direction counters.
// Picks next PCF from reset vector, EX redirect, stall hold, predicted target or PC+4.
module fetch_pc_predict #(
    parameter logic [31:0] RESET_VALUE_32 = 32'h1000_0000,
    parameter int unsigned BTB_ENTRIES    = 16
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        StallF,
    input  logic        RedirectE,
    input  logic [31:0] RedirectPCE,
    input  logic        ResolveValidE,
    input  logic [31:0] PCE,
    input  logic        TakenE,
    input  logic [31:0] TargetE,
    output logic [31:0] PCF,
    output logic [31:0] PC_plus4F,
    output logic        PredTakenF,
    output logic [31:0] PredTargetF
);

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = 32 - IDX_W - 2;

    logic [31:0]            pcf_q, pcf_d;
    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
    logic [31:0]            target_q [BTB_ENTRIES];
    logic [1:0]             ctr_q    [BTB_ENTRIES];

    logic [IDX_W-1:0] f_idx, e_idx;
    logic [TAG_W-1:0] f_tag, e_tag;
    logic             f_hit, e_hit;
    logic             train_we;
    logic [1:0]       train_ctr;
    logic             unused_pce_lo;

    // Fetch-side lookup on the current PC (pre-edge BTB contents).
    assign f_idx       = PCF[IDX_W+1:2];
    assign f_tag       = PCF[31:IDX_W+2];
    assign f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign PCF         = pcf_q;
    assign PC_plus4F   = pcf_q + 32'd4;
    assign PredTakenF  = f_hit && ctr_q[f_idx][1];
    assign PredTargetF = f_hit ? target_q[f_idx] : PC_plus4F;

    // Resolve-side lookup for training.
    assign e_idx         = PCE[IDX_W+1:2];
    assign e_tag         = PCE[31:IDX_W+2];
    assign e_hit         = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
    assign unused_pce_lo = ^PCE[1:0];

    // Next fetch PC: redirect beats stall, stall beats prediction.
    always_comb begin
        pcf_d = PC_plus4F;
        if (RedirectE) begin
            pcf_d = RedirectPCE;
        end else if (StallF) begin
            pcf_d = pcf_q;
        end else if (PredTakenF) begin
            pcf_d = PredTargetF;
        end
    end

    // Training decision: saturating update on hit, allocate weakly-taken on taken miss.
    always_comb begin
        train_we  = 1'b0;
        train_ctr = ctr_q[e_idx];
        if (ResolveValidE) begin
            if (e_hit) begin
                train_we = 1'b1;
                if (TakenE) begin
                    train_ctr = (ctr_q[e_idx] == 2'b11) ? 2'b11 : ctr_q[e_idx] + 2'd1;
                end else begin
                    train_ctr = (ctr_q[e_idx] == 2'b00) ? 2'b00 : ctr_q[e_idx] - 2'd1;
                end
            end else if (TakenE) begin
                train_we  = 1'b1;
                train_ctr = 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            pcf_q   <= RESET_VALUE_32;
            valid_q <= '0;
        end else begin
            pcf_q <= pcf_d;
            if (train_we) begin
                valid_q[e_idx] <= 1'b1;
                tag_q[e_idx]   <= e_tag;
                ctr_q[e_idx]   <= train_ctr;
                if (TakenE) begin
                    target_q[e_idx] <= TargetE;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_predict.sv
// Directed bench for fetch_pc_predict: a table-level BTB model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_fetch_pc_predict;

    localparam int NENT = 16;
    localparam logic [31:0] RST_PC = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        n_rst = 1'b1;
    logic        StallF = 1'b0, RedirectE = 1'b0, ResolveValidE = 1'b0, TakenE = 1'b0;
    logic [31:0] RedirectPCE = '0, PCE = '0, TargetE = '0;
    logic [31:0] PCF, PC_plus4F, PredTargetF;
    logic        PredTakenF;

    fetch_pc_predict #(.RESET_VALUE_32(RST_PC), .BTB_ENTRIES(NENT)) dut (
        .clk(clk), .n_rst(n_rst), .StallF(StallF), .RedirectE(RedirectE),
        .RedirectPCE(RedirectPCE), .ResolveValidE(ResolveValidE), .PCE(PCE),
        .TakenE(TakenE), .TargetE(TargetE), .PCF(PCF), .PC_plus4F(PC_plus4F),
        .PredTakenF(PredTakenF), .PredTargetF(PredTargetF)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: each slot remembers the word-aligned PC that owns it.
    bit          m_valid [NENT];
    logic [31:0] m_owner [NENT];
    logic [31:0] m_tgt   [NENT];
    int          m_ctr   [NENT];
    logic [31:0] m_pc;
    bit          m_en = 0;

    function automatic int slot(input logic [31:0] pc);
        return int'((pc >> 2) % NENT);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        int s = slot(pc);
        return m_valid[s] && ((m_owner[s] / (NENT * 4)) == (pc / (NENT * 4)));
    endfunction

    function automatic bit m_ptaken(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[slot(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_ptarget(input logic [31:0] pc);
        return m_hit(pc) ? m_tgt[slot(pc)] : pc + 32'd4;
    endfunction

    always @(posedge clk) begin
        logic [31:0] nxt;
        int s;
        if (n_rst) begin
            m_pc = RST_PC;
            for (int i = 0; i < NENT; i++) m_valid[i] = 0;
            m_en = 1;
        end else begin
            if (RedirectE)             nxt = RedirectPCE;
            else if (StallF)           nxt = m_pc;
            else if (m_ptaken(m_pc))   nxt = m_ptarget(m_pc);
            else                       nxt = m_pc + 32'd4;
            if (ResolveValidE) begin
                s = slot(PCE);
                if (m_hit(PCE)) begin
                    if (TakenE) begin
                        m_ctr[s] = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1;
                        m_tgt[s] = TargetE;
                    end else begin
                        m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
                    end
                end else if (TakenE) begin
                    m_valid[s] = 1;
                    m_owner[s] = {PCE[31:2], 2'b00};
                    m_tgt[s]   = TargetE;
                    m_ctr[s]   = 2;
                end
            end
            m_pc = nxt;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_en) begin
            chk("model PCF", PCF, m_pc);
            chk("model PC_plus4F", PC_plus4F, m_pc + 32'd4);
            chk("model PredTakenF", 32'(PredTakenF), 32'(m_ptaken(m_pc)));
            chk("model PredTargetF", PredTargetF, m_ptarget(m_pc));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        ResolveValidE = 1'b1; PCE = pc; TakenE = tk; TargetE = tgt;
    endtask

    task automatic redirect(input logic [31:0] pc);
        RedirectE = 1'b1; RedirectPCE = pc;
    endtask

    task automatic idle();
        ResolveValidE = 1'b0; TakenE = 1'b0; RedirectE = 1'b0; StallF = 1'b0;
    endtask

    initial begin
        // Reset for two edges.
        tick(); tick();
        n_rst = 1'b0;
        chk("reset PCF", PCF, 32'h1000_0000);
        chk("reset PC_plus4F", PC_plus4F, 32'h1000_0004);
        chk("reset PredTakenF", 32'(PredTakenF), 32'd0);
        chk("reset PredTargetF", PredTargetF, 32'h1000_0004);
        tick(); chk("seq +4", PCF, 32'h1000_0004);
        tick(); chk("seq +8", PCF, 32'h1000_0008);

        // Allocate then predict.
        resolve(32'h1000_0010, 1'b1, 32'h1000_0100);
        tick(); idle();
        chk("alloc PCF", PCF, 32'h1000_000C);
        chk("alloc PredTakenF off", 32'(PredTakenF), 32'd0);
        tick();
        chk("predict PredTakenF", 32'(PredTakenF), 32'd1);
        chk("predict PredTargetF", PredTargetF, 32'h1000_0100);
        tick(); chk("predict next PCF", PCF, 32'h1000_0100);

        // Counter decay 2 -> 1 -> 0, then one more not-taken stays at 0.
        resolve(32'h1000_0010, 1'b0, 32'h0);
        tick(); tick(); idle();
        redirect(32'h1000_0010);
        tick(); idle();
        chk("decay PredTakenF", 32'(PredTakenF), 32'd0);
        chk("decay PredTargetF", PredTargetF, 32'h1000_0100);
        tick(); chk("decay next PCF", PCF, 32'h1000_0014);
        resolve(32'h1000_0010, 1'b0, 32'h0);
        tick(); idle();
        // A single taken from saturated-low only reaches 1: still not-taken.
        resolve(32'h1000_0010, 1'b1, 32'h1000_0180);
        redirect(32'h1000_0010);
        tick(); idle();
        chk("sat low PredTakenF", 32'(PredTakenF), 32'd0);
        tick(); chk("sat low next PCF", PCF, 32'h1000_0014);

        // Redirect beats stall; stall alone holds.
        StallF = 1'b1; redirect(32'h1000_0200);
        tick(); RedirectE = 1'b0;
        chk("redir over stall", PCF, 32'h1000_0200);
        for (int i = 0; i < 3; i++) begin
            tick(); chk("stall hold", PCF, 32'h1000_0200);
        end
        idle();

        // Alias: same index, different tag.
        redirect(32'h2000_0010);
        tick(); idle();
        chk("alias PredTakenF", 32'(PredTakenF), 32'd0);
        chk("alias PredTargetF", PredTargetF, 32'h2000_0014);
        tick(); chk("alias next PCF", PCF, 32'h2000_0014);
        resolve(32'h2000_0010, 1'b1, 32'h2000_0300);
        tick(); idle();
        redirect(32'h1000_0010);
        tick(); idle();
        chk("evicted PredTakenF", 32'(PredTakenF), 32'd0);
        redirect(32'h2000_0010);
        tick(); idle();
        chk("owner PredTakenF", 32'(PredTakenF), 32'd1);
        tick(); chk("owner next PCF", PCF, 32'h2000_0300);

        // Wrap and same-cycle train of the current fetch index.
        redirect(32'hFFFF_FFFC);
        tick(); idle();
        chk("wrap PC_plus4F", PC_plus4F, 32'h0000_0000);
        resolve(32'hFFFF_FFFC, 1'b1, 32'h0000_0040);
        chk("same-cycle old PredTakenF", 32'(PredTakenF), 32'd0);
        tick(); idle();
        chk("wrap next PCF", PCF, 32'h0000_0000);
        redirect(32'hFFFF_FFFC);
        tick(); idle();
        chk("same-cycle new PredTakenF", 32'(PredTakenF), 32'd1);
        chk("same-cycle new PredTargetF", PredTargetF, 32'h0000_0040);
        tick(); chk("trained next PCF", PCF, 32'h0000_0040);

        // Mid-run reset drops pending training and clears the table.
        n_rst = 1'b1;
        resolve(32'h1000_0000, 1'b1, 32'h1000_0500);
        tick(); idle(); n_rst = 1'b0;
        chk("mid reset PCF", PCF, 32'h1000_0000);
        chk("mid reset PredTakenF", 32'(PredTakenF), 32'd0);
        tick(); chk("mid reset next PCF", PCF, 32'h1000_0004);
        redirect(32'h2000_0010);
        tick(); idle();
        chk("cleared PredTakenF", 32'(PredTakenF), 32'd0);
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
